// File: rtl/atm_pkg.sv
// Shared definitions for the ATM terminal front end and the ATM core:
// FSM state encoding, menu codes, keypad codes, field widths and limits,
// and the request payload struct carried on the request handshake.
package atm_pkg;

  localparam int unsigned ACC_W  = 3;
  localparam int unsigned PIN_W  = 13;
  localparam int unsigned MENU_W = 3;
  localparam int unsigned AMT_W  = 16;
  localparam int unsigned BAL_W  = 16;
  localparam int unsigned KEY_W  = 4;

  localparam int unsigned PIN_MAX = 8191;
  localparam int unsigned AMT_MAX = 65535;

  // Menu codes shared with the core
  localparam logic [MENU_W-1:0] MENU_CHANGEPIN = 3'd4;
  localparam logic [MENU_W-1:0] MENU_WITHDRAW  = 3'd5;
  localparam logic [MENU_W-1:0] MENU_BALANCE   = 3'd6;
  localparam logic [MENU_W-1:0] MENU_DEPOSIT   = 3'd7;

  // Keypad control codes; digits are 0-9, 13-15 are ignored
  localparam logic [KEY_W-1:0] KEY_ENTER  = 4'd10;
  localparam logic [KEY_W-1:0] KEY_CANCEL = 4'd11;
  localparam logic [KEY_W-1:0] KEY_CLEAR  = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_PIN,
    S_GET_LANG,
    S_GET_MENU,
    S_GET_AMOUNT,
    S_GET_NEWPIN,
    S_SEND,
    S_WAIT_RSP
  } state_t;

  // Transaction request payload
  typedef struct packed {
    logic [ACC_W-1:0]  acc_number;
    logic [PIN_W-1:0]  pin;
    logic [PIN_W-1:0]  new_pin;
    logic [MENU_W-1:0] menu_option;
    logic [AMT_W-1:0]  amount;
    logic              lan;
  } req_t;

endpackage

// File: rtl/atm_terminal_frontend_if.sv
// Request/response bus between the terminal front end (master) and the
// ATM core (slave).
//   req, req_valid      : request payload and pending flag (master -> slave)
//   req_ready           : core accepts the request (slave -> master)
//   rsp_valid/error/bal : response strobe, error flag, balance (slave -> master)
interface atm_terminal_frontend_if;
  import atm_pkg::*;

  req_t             req;
  logic             req_valid;
  logic             req_ready;
  logic             rsp_valid;
  logic             rsp_error;
  logic [BAL_W-1:0] rsp_balance;

  modport master (
    output req, req_valid,
    input  req_ready, rsp_valid, rsp_error, rsp_balance
  );

  modport slave (
    input  req, req_valid,
    output req_ready, rsp_valid, rsp_error, rsp_balance
  );

endinterface

// File: rtl/atm_terminal_frontend_bcd_accumulator.sv
// Decimal digit accumulator shared by all numeric entry fields.
//   value_in  : current value of the active field (muxed by the caller)
//   max_val   : largest legal value for the active field
//   digit     : decimal digit 0-9
//   load      : accept digit this cycle (bumps the digit count)
//   clear     : zero the digit count (priority over load)
//   result_c  : value_in*10 + digit, truncated to W bits
//   ovf_c     : result exceeds max_val
//   count     : digits accepted since the last clear/overflow
module bcd_accumulator #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [3:0]       digit,
  input  logic [W-1:0]     value_in,
  input  logic [W-1:0]     max_val,
  output logic [W-1:0]     result_c,
  output logic             ovf_c,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned SUM_W = 17;

  logic [SUM_W-1:0] sum_c;

  // Digit counts are bounded upstream, so 17 bits never wraps
  assign sum_c    = SUM_W'(value_in) * SUM_W'(10) + SUM_W'(digit);
  assign ovf_c    = sum_c > SUM_W'(max_val);
  assign result_c = W'(sum_c);

  // An overflowing digit restarts the entry, so the count restarts too
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= ovf_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/atm_terminal_frontend.sv
// Customer-side initiator for the ATM core. Collects card and keypad input,
// builds one transaction request per session, hands it to the core over a
// valid/ready bus and latches the core's response for the display.
//   clk, rst              : clock, synchronous active-high reset
//   card_insert, card_acc : session start pulse and card account number
//   key_valid, key_code   : keypad strobe and code (0-9, ENTER, CANCEL, CLEAR)
//   lan_sel               : language switch, taken on ENTER in GET_LANG
//   bus                   : request/response bus (master side)
//   disp_balance/error    : latched response (error also set on timeout)
//   entry_error           : one-cycle pulse on a rejected entry
//   busy                  : session in progress
module atm_terminal_frontend
  import atm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned PIN_DIGITS     = 4,
  parameter int unsigned AMT_DIGITS     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    card_insert,
  input  logic [ACC_W-1:0]        card_acc,
  input  logic                    key_valid,
  input  logic [KEY_W-1:0]        key_code,
  input  logic                    lan_sel,
  atm_terminal_frontend_if.master bus,
  output logic [BAL_W-1:0]        disp_balance,
  output logic                    disp_error,
  output logic                    entry_error,
  output logic                    busy
);

  localparam int unsigned MAX_DIG = (PIN_DIGITS > AMT_DIGITS) ? PIN_DIGITS : AMT_DIGITS;
  localparam int unsigned CNT_W   = $clog2(MAX_DIG + 1);
  localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nx;
  req_t             req_q, req_nx;
  logic             req_valid_q;
  logic [TMR_W-1:0] timer, timer_nx;
  logic [BAL_W-1:0] disp_bal_nx;
  logic             disp_err_nx;
  logic             err_nx;

  logic             dig_key, enter_key, clear_key, cancel_key;
  logic             in_entry, can_timeout, key_act;

  logic             acc_load, acc_clr, acc_clr_all;
  logic [AMT_W-1:0] acc_in, acc_max, acc_result, fld_val;
  logic             acc_ovf, fld_wr;
  logic [CNT_W-1:0] acc_count;

  assign dig_key    = key_valid && (key_code <= 4'd9);
  assign enter_key  = key_valid && (key_code == KEY_ENTER);
  assign clear_key  = key_valid && (key_code == KEY_CLEAR);
  assign cancel_key = key_valid && (key_code == KEY_CANCEL);

  assign in_entry    = state inside {S_GET_PIN, S_GET_LANG, S_GET_MENU, S_GET_AMOUNT, S_GET_NEWPIN};
  assign can_timeout = in_entry || (state == S_WAIT_RSP);
  // Codes 13-15 are not keys at all and do not count as activity
  assign key_act     = in_entry && key_valid && (key_code <= KEY_CLEAR);

  assign bus.req       = req_q;
  assign bus.req_valid = req_valid_q;

  // Route the active numeric field and its limit into the shared accumulator
  always_comb begin
    acc_in  = req_q.amount;
    acc_max = AMT_W'(AMT_MAX);
    case (state)
      S_GET_PIN: begin
        acc_in  = AMT_W'(req_q.pin);
        acc_max = AMT_W'(PIN_MAX);
      end
      S_GET_NEWPIN: begin
        acc_in  = AMT_W'(req_q.new_pin);
        acc_max = AMT_W'(PIN_MAX);
      end
      default: ;
    endcase
  end

  // Every field change of state starts the next field with zero digits
  assign acc_clr_all = acc_clr || (state_nx != state);

  bcd_accumulator #(
    .W     (AMT_W),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (acc_clr_all),
    .load     (acc_load),
    .digit    (key_code),
    .value_in (acc_in),
    .max_val  (acc_max),
    .result_c (acc_result),
    .ovf_c    (acc_ovf),
    .count    (acc_count)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, field updates, display and timeout
  always_comb begin
    state_nx    = state;
    req_nx      = req_q;
    disp_bal_nx = disp_balance;
    disp_err_nx = disp_error;
    err_nx      = 1'b0;
    acc_load    = 1'b0;
    acc_clr     = 1'b0;
    fld_wr      = 1'b0;
    fld_val     = '0;

    case (state)
      S_IDLE: begin
        if (card_insert) begin
          req_nx            = '0;
          req_nx.acc_number = card_acc;
          state_nx          = S_GET_PIN;
        end
      end

      S_GET_PIN, S_GET_NEWPIN: begin
        if (dig_key) begin
          if (acc_count < CNT_W'(PIN_DIGITS)) begin
            acc_load = 1'b1;
            err_nx   = acc_ovf;
            fld_wr   = 1'b1;
            fld_val  = acc_ovf ? '0 : acc_result;
          end
        end else if (enter_key) begin
          if (acc_count == CNT_W'(PIN_DIGITS)) begin
            state_nx = (state == S_GET_PIN) ? S_GET_LANG : S_SEND;
          end else begin
            err_nx  = 1'b1;
            acc_clr = 1'b1;
            fld_wr  = 1'b1;
          end
        end else if (clear_key) begin
          acc_clr = 1'b1;
          fld_wr  = 1'b1;
        end
      end

      S_GET_LANG: begin
        if (enter_key) begin
          req_nx.lan = lan_sel;
          state_nx   = S_GET_MENU;
        end
      end

      S_GET_MENU: begin
        if (dig_key) begin
          if (key_code == {1'b0, MENU_CHANGEPIN}) begin
            req_nx.menu_option = MENU_CHANGEPIN;
            state_nx           = S_GET_NEWPIN;
          end else if (key_code == {1'b0, MENU_WITHDRAW}) begin
            req_nx.menu_option = MENU_WITHDRAW;
            state_nx           = S_GET_AMOUNT;
          end else if (key_code == {1'b0, MENU_BALANCE}) begin
            req_nx.menu_option = MENU_BALANCE;
            state_nx           = S_SEND;
          end else if (key_code == {1'b0, MENU_DEPOSIT}) begin
            req_nx.menu_option = MENU_DEPOSIT;
            state_nx           = S_GET_AMOUNT;
          end else begin
            err_nx = 1'b1;
          end
        end
      end

      S_GET_AMOUNT: begin
        if (dig_key) begin
          if (acc_count < CNT_W'(AMT_DIGITS)) begin
            acc_load = 1'b1;
            err_nx   = acc_ovf;
            fld_wr   = 1'b1;
            fld_val  = acc_ovf ? '0 : acc_result;
          end
        end else if (enter_key) begin
          // An empty amount is rejected rather than sent
          if (acc_count != '0) state_nx = S_SEND;
          else                 err_nx   = 1'b1;
        end else if (clear_key) begin
          acc_clr = 1'b1;
          fld_wr  = 1'b1;
        end
      end

      S_SEND: begin
        if (bus.req_ready) state_nx = S_WAIT_RSP;
      end

      S_WAIT_RSP: begin
        if (bus.rsp_valid) begin
          disp_bal_nx = bus.rsp_balance;
          disp_err_nx = bus.rsp_error;
          req_nx      = '0;
          state_nx    = S_IDLE;
        end
      end

      default: state_nx = S_IDLE;
    endcase

    if (fld_wr) begin
      case (state)
        S_GET_PIN:    req_nx.pin     = PIN_W'(fld_val);
        S_GET_NEWPIN: req_nx.new_pin = PIN_W'(fld_val);
        default:      req_nx.amount  = fld_val;
      endcase
    end

    if (in_entry && cancel_key) begin
      req_nx   = '0;
      state_nx = S_IDLE;
    end

    // Timeout only trips on a cycle where nothing else happened
    if (can_timeout && !key_act && (state_nx == state) &&
        (timer == TMR_W'(TIMEOUT_CYCLES - 1))) begin
      req_nx      = '0;
      disp_err_nx = 1'b1;
      state_nx    = S_IDLE;
    end

    if (!can_timeout || key_act || (state_nx != state)) timer_nx = '0;
    else                                                 timer_nx = timer + TMR_W'(1);
  end

  // Request fields, display and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= '0;
      req_valid_q  <= 1'b0;
      timer        <= '0;
      disp_balance <= '0;
      disp_error   <= 1'b0;
      entry_error  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      req_q        <= req_nx;
      req_valid_q  <= (state_nx == S_SEND);
      timer        <= timer_nx;
      disp_balance <= disp_bal_nx;
      disp_error   <= disp_err_nx;
      entry_error  <= err_nx;
      busy         <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_atm_terminal_frontend.sv
// Directed bench for atm_terminal_frontend: balance, withdraw, PIN entry
// boundaries, change PIN with backpressure, reset, cancel and timeout.
module tb_atm_terminal_frontend;
  import atm_pkg::*;

  localparam int unsigned TMO = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             card_insert;
  logic [ACC_W-1:0] card_acc;
  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic             lan_sel;
  logic [BAL_W-1:0] disp_balance;
  logic             disp_error;
  logic             entry_error;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  atm_terminal_frontend_if bus ();

  atm_terminal_frontend #(
    .TIMEOUT_CYCLES (TMO),
    .PIN_DIGITS     (4),
    .AMT_DIGITS     (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .card_insert  (card_insert),
    .card_acc     (card_acc),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .lan_sel      (lan_sel),
    .bus          (bus),
    .disp_balance (disp_balance),
    .disp_error   (disp_error),
    .entry_error  (entry_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic card(input logic [2:0] a);
    card_insert = 1'b1;
    card_acc    = a;
    step();
    card_insert = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  initial begin
    logic stable;
    rst = 1'b1; card_insert = 1'b0; card_acc = '0; key_valid = 1'b0;
    key_code = '0; lan_sel = 1'b0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_error = 1'b0; bus.rsp_balance = '0;
    step(); step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_req_valid", 32'(bus.req_valid), 0);
    check("rst_disp_bal", 32'(disp_balance), 0);
    check("rst_req", 32'(bus.req.pin), 0);

    // Balance session
    press(4'd5);                       // ignored in IDLE
    check("idle_key_ignored", 32'(busy), 0);
    card(3'd1);
    check("card_busy", 32'(busy), 1);
    card(3'd6);                        // ignored outside IDLE
    check("card_ignored", 32'(bus.req.acc_number), 1);
    press(4'd1); press(4'd0); press(4'd0); press(4'd0);
    check("bal_pin", 32'(bus.req.pin), 1000);
    press(KEY_ENTER);
    lan_sel = 1'b1;
    press(KEY_ENTER);
    lan_sel = 1'b0;
    check("bal_lan", 32'(bus.req.lan), 1);
    check("bal_no_valid_yet", 32'(bus.req_valid), 0);
    press(4'd6);
    check("bal_req_valid", 32'(bus.req_valid), 1);
    check("bal_menu", 32'(bus.req.menu_option), 6);
    check("bal_acc", 32'(bus.req.acc_number), 1);
    check("bal_amount", 32'(bus.req.amount), 0);
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    check("bal_valid_fall", 32'(bus.req_valid), 0);
    check("bal_wait_busy", 32'(busy), 1);
    bus.rsp_valid = 1'b1; bus.rsp_balance = 16'd500; bus.rsp_error = 1'b0;
    step();
    bus.rsp_valid = 1'b0;
    check("bal_disp_bal", 32'(disp_balance), 500);
    check("bal_disp_err", 32'(disp_error), 0);
    check("bal_idle", 32'(busy), 0);
    check("bal_cleared", 32'(bus.req.pin), 0);

    // Withdraw overdraft
    card(3'd3);
    press(4'd1); press(4'd0); press(4'd1); press(4'd0); press(KEY_ENTER);
    press(KEY_ENTER);
    press(4'd5);
    press(4'd6); press(4'd0); press(4'd0); press(KEY_ENTER);
    check("wd_valid", 32'(bus.req_valid), 1);
    check("wd_amount", 32'(bus.req.amount), 600);
    check("wd_menu", 32'(bus.req.menu_option), 5);
    check("wd_pin", 32'(bus.req.pin), 1010);
    check("wd_lan", 32'(bus.req.lan), 0);
    // response in the handshake cycle must be ignored
    bus.req_ready = 1'b1; bus.rsp_valid = 1'b1; bus.rsp_balance = 16'd777; bus.rsp_error = 1'b0;
    step();
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0;
    check("wd_rsp_ignored", 32'(disp_balance), 500);
    check("wd_still_busy", 32'(busy), 1);
    bus.rsp_valid = 1'b1; bus.rsp_balance = 16'd500; bus.rsp_error = 1'b1;
    step();
    bus.rsp_valid = 1'b0; bus.rsp_error = 1'b0;
    check("wd_disp_err", 32'(disp_error), 1);
    check("wd_disp_bal", 32'(disp_balance), 500);

    // PIN entry boundaries, then change PIN
    card(3'd2);
    press(4'd9); press(4'd9); press(4'd9);
    check("ovf_pre", 32'(bus.req.pin), 999);
    press(4'd9);
    check("ovf_err", 32'(entry_error), 1);
    check("ovf_pin", 32'(bus.req.pin), 0);
    check("ovf_busy", 32'(busy), 1);
    step();
    check("ovf_pulse", 32'(entry_error), 0);
    press(4'd5); press(KEY_ENTER);
    check("short_err", 32'(entry_error), 1);
    check("short_pin", 32'(bus.req.pin), 0);
    press(4'd3); press(KEY_CLEAR);
    check("clear_pin", 32'(bus.req.pin), 0);
    press(4'd8); press(4'd0); press(4'd0); press(4'd0); press(4'd9);
    check("extra_digit", 32'(bus.req.pin), 8000);
    press(KEY_ENTER);
    press(KEY_ENTER);
    press(4'd3);
    check("menu_bad", 32'(entry_error), 1);
    press(4'd4);
    check("menu_cp", 32'(bus.req.menu_option), 4);
    check("menu_ok", 32'(entry_error), 0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_ENTER);
    check("cp_valid", 32'(bus.req_valid), 1);
    check("cp_newpin", 32'(bus.req.new_pin), 1234);
    check("cp_pin", 32'(bus.req.pin), 8000);

    // Backpressure longer than the timeout: SEND must hold
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.req_valid !== 1'b1 || bus.req.new_pin !== 13'd1234 || bus.req.pin !== 13'd8000)
        stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 1);
    check("bp_no_timeout", 32'(disp_error), 1);
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    check("bp_wait", 32'(busy), 1);

    // Reset in WAIT_RSP
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_busy", 32'(busy), 0);
    check("rstw_disp_err", 32'(disp_error), 0);
    check("rstw_disp_bal", 32'(disp_balance), 0);
    check("rstw_newpin", 32'(bus.req.new_pin), 0);

    // Amount overflow and CANCEL
    card(3'd4);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_ENTER);
    lan_sel = 1'b1;
    press(KEY_ENTER);
    lan_sel = 1'b0;
    press(4'd7);
    press(KEY_ENTER);
    check("amt_empty_err", 32'(entry_error), 1);
    press(4'd6); press(4'd5); press(4'd5); press(4'd3); press(4'd6);
    check("amt_ovf_err", 32'(entry_error), 1);
    check("amt_ovf_val", 32'(bus.req.amount), 0);
    press(4'd9); press(4'd9);
    check("amt_99", 32'(bus.req.amount), 99);
    press(KEY_CANCEL);
    check("cancel_idle", 32'(busy), 0);
    check("cancel_amount", 32'(bus.req.amount), 0);
    check("cancel_acc", 32'(bus.req.acc_number), 0);
    check("cancel_lan", 32'(bus.req.lan), 0);
    check("cancel_menu", 32'(bus.req.menu_option), 0);

    // Timeout in GET_MENU
    card(3'd5);
    press(4'd1); press(4'd1); press(4'd1); press(4'd1); press(KEY_ENTER);
    press(KEY_ENTER);
    for (int i = 0; i < int'(TMO) - 1; i++) step();
    check("tmo_not_yet", 32'(busy), 1);
    check("tmo_err_not_yet", 32'(disp_error), 0);
    step();
    check("tmo_idle", 32'(busy), 0);
    check("tmo_disp_err", 32'(disp_error), 1);
    check("tmo_cleared", 32'(bus.req.pin), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
